player_input_ctrl: RTL and testbench

Decodes a PS/2 keyboard stream into the per-player control levels consumed by the player motion block (`right`, `left`, `jump`, `squat`, `defend`). It sits directly upstream of player motion.
- Its outputs are snapshotted on the game `frame_tick`, so player motion sees stable values for a whole frame.
- A short jump press is never lost between ticks.

---
 rtl/game_pkg.sv | 33 +++
 rtl/player_input_ctrl_if.sv | 22 ++
 rtl/player_input_ctrl_ps2_rx.sv | 101 ++++++++++
 rtl/player_input_ctrl.sv | 112 +++++++++++
 tb/tb_player_input_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared scan-code constants, receiver state encoding and key-state layout
// for the player input path.
package game_pkg;

    localparam logic [7:0] SC_D       = 8'h23;
    localparam logic [7:0] SC_A       = 8'h1C;
    localparam logic [7:0] SC_W       = 8'h1D;
    localparam logic [7:0] SC_S       = 8'h1B;
    localparam logic [7:0] SC_SPACE   = 8'h29;

    localparam logic [7:0] SC_EXT     = 8'hE0;
    localparam logic [7:0] SC_BRK     = 8'hF0;
    localparam logic [7:0] SC_X_RIGHT = 8'h74;
    localparam logic [7:0] SC_X_LEFT  = 8'h6B;
    localparam logic [7:0] SC_X_UP    = 8'h75;
    localparam logic [7:0] SC_X_DOWN  = 8'h72;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef struct packed {
        logic defend;
        logic squat;
        logic jump;
        logic left;
        logic right;
    } keys_t;

endpackage

// File: rtl/player_input_ctrl_if.sv
// Raw PS/2 pins and frame tick in, per-frame player control levels out.
interface player_input_ctrl_if;
    logic ps2_clk;
    logic ps2_data;
    logic frame_tick;
    logic right;
    logic left;
    logic jump;
    logic squat;
    logic defend;
    logic frame_err;

    modport master (
        output ps2_clk, ps2_data, frame_tick,
        input  right, left, jump, squat, defend, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data, frame_tick,
        output right, left, jump, squat, defend, frame_err
    );
endinterface

// File: rtl/player_input_ctrl_ps2_rx.sv
// PS/2 byte receiver: pin synchronisers, falling-edge detect, framing FSM
// with parity/stop checks and an inactivity timeout.
module ps2_rx
    import game_pkg::*;
#(
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       byte_err
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_prev;
    logic          fall;
    rx_state_t     state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          parity;
    logic [TW-1:0] tcnt;

    // Synchronisers reset to the idle-high bus level so reset release
    // cannot fake a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fall = clk_prev & ~clk_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RX_IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            parity     <= 1'b0;
            tcnt       <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
            if (state != RX_IDLE && !fall && tcnt == TW'(TIMEOUT)) begin
                state    <= RX_IDLE;
                tcnt     <= '0;
                byte_err <= 1'b1;
            end else begin
                if (fall || state == RX_IDLE) begin
                    tcnt <= '0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
                if (fall) begin
                    case (state)
                        RX_IDLE: begin
                            if (!data_sync[1]) begin
                                state   <= RX_DATA;
                                bit_cnt <= '0;
                            end
                        end
                        RX_DATA: begin
                            shift   <= {data_sync[1], shift[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= RX_PARITY;
                            end
                        end
                        RX_PARITY: begin
                            parity <= data_sync[1];
                            state  <= RX_STOP;
                        end
                        RX_STOP: begin
                            state <= RX_IDLE;
                            if (data_sync[1] && (^{shift, parity})) begin
                                rx_byte    <= shift;
                                byte_valid <= 1'b1;
                            end else begin
                                byte_err <= 1'b1;
                            end
                        end
                        default: state <= RX_IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: rtl/player_input_ctrl.sv
// Scan-code decoder, key-state tracking, latched jump request and the
// per-frame output snapshot consumed by player motion.
module player_input_ctrl
    import game_pkg::*;
#(
    parameter logic [7:0]  KEY_RIGHT  = SC_D,
    parameter logic [7:0]  KEY_LEFT   = SC_A,
    parameter logic [7:0]  KEY_JUMP   = SC_W,
    parameter logic [7:0]  KEY_SQUAT  = SC_S,
    parameter logic [7:0]  KEY_DEFEND = SC_SPACE,
    parameter int unsigned TIMEOUT    = 50000
) (
    input logic           clk,
    input logic           rst_n,
    player_input_ctrl_if.slave bus
);
    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       byte_err;
    logic       ext;
    logic       brk;
    logic       jump_req;
    logic       is_key;
    logic       jump_make;
    keys_t      keys;
    keys_t      hit;
    keys_t      snap;

    ps2_rx #(.TIMEOUT(TIMEOUT)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (bus.ps2_clk),
        .ps2_data   (bus.ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .byte_err   (byte_err)
    );

    always_comb begin
        hit = '0;
        if (ext) begin
            case (rx_byte)
                SC_X_RIGHT: hit.right = 1'b1;
                SC_X_LEFT:  hit.left  = 1'b1;
                SC_X_UP:    hit.jump  = 1'b1;
                SC_X_DOWN:  hit.squat = 1'b1;
                default:    hit = '0;
            endcase
        end else begin
            hit.right  = (rx_byte == KEY_RIGHT);
            hit.left   = (rx_byte == KEY_LEFT);
            hit.jump   = (rx_byte == KEY_JUMP);
            hit.squat  = (rx_byte == KEY_SQUAT);
            hit.defend = (rx_byte == KEY_DEFEND);
        end
    end

    assign is_key    = byte_valid && rx_byte != SC_EXT && rx_byte != SC_BRK;
    // Only a fresh press arms the jump; typematic repeats find the bit set.
    assign jump_make = is_key && !brk && hit.jump && !keys.jump;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext  <= 1'b0;
            brk  <= 1'b0;
            keys <= '0;
        end else if (byte_valid) begin
            if (rx_byte == SC_EXT) begin
                ext <= 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk <= 1'b1;
            end else begin
                keys <= brk ? (keys & ~hit) : (keys | hit);
                ext  <= 1'b0;
                brk  <= 1'b0;
            end
        end else if (byte_err) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end
    end

    // A new request wins over the tick clear so it survives to the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jump_req <= 1'b0;
        end else if (jump_make) begin
            jump_req <= 1'b1;
        end else if (bus.frame_tick) begin
            jump_req <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap <= '0;
        end else if (bus.frame_tick) begin
            snap.right  <= keys.right & ~keys.left;
            snap.left   <= keys.left & ~keys.right;
            snap.jump   <= jump_req;
            snap.squat  <= keys.squat;
            snap.defend <= keys.defend;
        end
    end

    assign bus.right     = snap.right;
    assign bus.left      = snap.left;
    assign bus.jump      = snap.jump;
    assign bus.squat     = snap.squat;
    assign bus.defend    = snap.defend;
    assign bus.frame_err = byte_err;
endmodule

// File: tb/tb_player_input_ctrl.sv
// Drives PS/2 frames and frame ticks into player_input_ctrl and checks the
// snapshot outputs and error pulses against a key-table reference model.
module tb_player_input_ctrl;
    localparam int unsigned TO = 2000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   err_seen = 0;

    bit       held [5];
    bit       m_ext, m_brk, m_jreq;
    int       m_err = 0;
    logic [4:0] exp_out = '0;

    always #5 clk = ~clk;

    player_input_ctrl_if bus();

    player_input_ctrl #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(negedge clk) if (bus.frame_err === 1'b1) err_seen++;

    function automatic logic [4:0] outs();
        return {bus.defend, bus.squat, bus.jump, bus.left, bus.right};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Index: 0 right, 1 left, 2 jump, 3 squat, 4 defend; -1 unmapped.
    function automatic int key_index(input bit e, input logic [7:0] c);
        if (e) begin
            case (c)
                8'h74: return 0;
                8'h6B: return 1;
                8'h75: return 2;
                8'h72: return 3;
                default: return -1;
            endcase
        end
        case (c)
            8'h23: return 0;
            8'h1C: return 1;
            8'h1D: return 2;
            8'h1B: return 3;
            8'h29: return 4;
            default: return -1;
        endcase
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int k;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            k = key_index(m_ext, b);
            if (k >= 0) begin
                if (!m_brk && k == 2 && !held[2]) m_jreq = 1;
                held[k] = !m_brk;
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic model_reset();
        foreach (held[i]) held[i] = 0;
        m_ext = 0; m_brk = 0; m_jreq = 0;
        exp_out = '0;
    endtask

    task automatic ps2_bit(input logic v);
        bus.ps2_data = v;
        repeat (8) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (8) @(negedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(!bad_stop);
        bus.ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        if (bad_par || bad_stop) begin
            m_err++;
            m_ext = 0;
            m_brk = 0;
        end else begin
            model_byte(b);
        end
    endtask

    task automatic partial(input int nbits);
        ps2_bit(1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(1'b1);
        bus.ps2_data = 1'b1;
    endtask

    task automatic tick(input string tag);
        check({tag, "_hold"}, outs(), exp_out);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        exp_out = {held[4], held[3], m_jreq, held[1] & ~held[0], held[0] & ~held[1]};
        m_jreq = 0;
        @(negedge clk);
        check(tag, outs(), exp_out);
    endtask

    initial begin
        logic [7:0] pool [13];
        logic [7:0] b;
        int pick;
        pool = '{8'h23, 8'h1C, 8'h1D, 8'h1B, 8'h29, 8'hE0, 8'hF0,
                 8'h74, 8'h6B, 8'h75, 8'h72, 8'h6C, 8'h00};
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        bus.frame_tick = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_outs", outs(), 5'b0);
        check("reset_err", bus.frame_err, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        send(8'h23, 0, 0); tick("right_make");
        send(8'hF0, 0, 0); send(8'h23, 0, 0); tick("right_break");

        send(8'h1C, 0, 0); send(8'h23, 0, 0); tick("both_held");
        send(8'hF0, 0, 0); send(8'h23, 0, 0); tick("left_only");
        send(8'hF0, 0, 0); send(8'h1C, 0, 0); tick("left_break");

        send(8'h1D, 0, 0); tick("jump_1");
        send(8'h1D, 0, 0); tick("jump_rep1");
        send(8'h1D, 0, 0); tick("jump_rep2");
        send(8'hF0, 0, 0); send(8'h1D, 0, 0); tick("jump_rel");
        tick("jump_idle");

        send(8'h1D, 0, 0); send(8'hF0, 0, 0); send(8'h1D, 0, 0); tick("jump_tap");

        send(8'hE0, 0, 0); send(8'h74, 0, 0); tick("ext_right");
        send(8'hE0, 0, 0); send(8'hF0, 0, 0); send(8'h74, 0, 0); tick("ext_break");
        send(8'hE0, 0, 0); send(8'h6C, 0, 0); tick("ext_unmapped");

        send(8'h29, 0, 0); tick("defend_make");
        send(8'hF0, 0, 0); send(8'h29, 1, 0);
        check("err_parity", err_seen, m_err);
        send(8'h23, 0, 0); tick("after_parity");
        send(8'hF0, 0, 0); send(8'h1B, 0, 1);
        check("err_stop", err_seen, m_err);
        send(8'h1B, 0, 0); tick("after_stop");
        send(8'hF0, 0, 0); send(8'h23, 0, 0);
        send(8'hF0, 0, 0); send(8'h1B, 0, 0);
        send(8'hF0, 0, 0); send(8'h29, 0, 0); tick("all_clear");

        partial(4);
        repeat (TO + 50) @(negedge clk);
        m_err++;
        m_ext = 0;
        m_brk = 0;
        check("err_timeout", err_seen, m_err);
        send(8'h23, 0, 0); tick("after_timeout");

        partial(5);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("midreset_outs", outs(), 5'b0);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("midreset_err", err_seen, m_err);
        tick("post_reset_idle");
        send(8'h23, 0, 0); tick("post_reset_right");

        for (int n = 0; n < 40; n++) begin
            pick = $urandom_range(0, 12);
            b = (pick == 12) ? 8'($urandom_range(0, 255)) : pool[pick];
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 0) send(b, 1, 0);
                else send(b, 0, 1);
            end else begin
                send(b, 0, 0);
            end
            if ($urandom_range(0, 2) == 0) tick("rand");
        end
        tick("rand_final");
        check("err_total", err_seen, m_err);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
